// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared state encoding, PE latency and sign-extension helper for PE controllers
package pe_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} pe_seq_state_t;
   localparam int PE_MODEL_LATENCY = 2;
   localparam int SEXT_W = 32;
   function automatic logic [SEXT_W-1:0] sext8(input logic [7:0] v);
      return {{(SEXT_W-8){v[7]}}, v};
   endfunction
endpackage

// File: rtl/pe_tag_pipe.sv
// pe_tag_pipe: fixed-depth valid shift register that tracks which PE pipeline slots hold real work
module pe_tag_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic push,
   output logic retire,
   output logic empty
);
   logic [DEPTH-1:0] r_tags;
   // Newest tag enters at bit 0, oldest leaves from the MSB as the retire flag
   always_ff @(posedge clock) begin
      if (reset) r_tags <= '0;
      else r_tags <= (r_tags << 1) | DEPTH'(push);
   end
   assign retire = r_tags[DEPTH-1];
   // True when nothing remains once the current retire shifts out, not counting this cycle's push
   assign empty = (r_tags << 1) == '0;
endmodule

// File: rtl/pe_dot_sequencer.sv
// pe_dot_sequencer: streams a job of operand pairs through one PE and accumulates its products
module pe_dot_sequencer
   import pe_ctrl_pkg::*;
#(
   parameter int PE_LATENCY = PE_MODEL_LATENCY,
   parameter int LEN_W = 10,
   parameter int ACC_W = 20
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_feature,
   input  logic [7:0]       in_filter,
   output logic [7:0]       pe_feature,
   output logic [7:0]       pe_filter,
   input  logic [7:0]       pe_product,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             busy
);
   pe_seq_state_t    r_state;
   logic [LEN_W-1:0] r_remaining;
   logic [ACC_W-1:0] r_acc;
   logic             w_in_fire;
   logic             w_cfg_fire;
   logic             w_retire;
   logic             w_empty;
   logic [ACC_W-1:0] w_prod_ext;

   assign cfg_ready  = r_state == IDLE;
   assign in_ready   = r_state == ISSUE;
   assign out_valid  = r_state == DONE;
   assign busy       = r_state != IDLE;
   assign out_sum    = r_acc;
   assign w_cfg_fire = cfg_valid && cfg_ready;
   assign w_in_fire  = in_valid && in_ready;
   assign pe_feature = w_in_fire ? in_feature : 8'h00;
   assign pe_filter  = w_in_fire ? in_filter : 8'h00;
   assign w_prod_ext = ACC_W'(sext8(pe_product));

   pe_tag_pipe #(.DEPTH(PE_LATENCY)) u_tags (
      .clock (clock),
      .reset (reset),
      .push  (w_in_fire),
      .retire(w_retire),
      .empty (w_empty)
   );

   // Job FSM plus accumulation of tagged PE products
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_remaining <= '0;
         r_acc       <= '0;
      end else begin
         if (w_cfg_fire) r_acc <= '0;
         else if (w_retire) r_acc <= r_acc + w_prod_ext;
         case (r_state)
            IDLE: if (cfg_valid) begin
               r_remaining <= cfg_len;
               r_state     <= (cfg_len == '0) ? DONE : ISSUE;
            end
            ISSUE: if (in_valid) begin
               r_remaining <= r_remaining - LEN_W'(1);
               if (r_remaining == LEN_W'(1)) r_state <= DRAIN;
            end
            DRAIN: if (w_empty) r_state <= DONE;
            DONE: if (out_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_dot_sequencer.sv
// tb_pe_dot_sequencer: scoreboard bench for pe_dot_sequencer with a behavioural sign-magnitude PE attached
module tb_pe_dot_sequencer;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_valid = 1'b0;
   logic [9:0]  cfg_len = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_feature = '0;
   logic [7:0]  in_filter = '0;
   logic        out_ready = 1'b0;
   logic        cfg_ready, in_ready, out_valid, busy;
   logic [7:0]  pe_feature, pe_filter;
   logic [7:0]  pe_s1 = '0;
   logic [7:0]  pe_product = '0;
   logic [19:0] out_sum;
   logic [19:0] exp_q[$];
   logic [19:0] exp_v;
   int          checks = 0;
   int          failures = 0;
   int          n_acc = 0;
   int          n_ir = 0;

   pe_dot_sequencer dut (
      .clock(clock), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_feature(in_feature), .in_filter(in_filter),
      .pe_feature(pe_feature), .pe_filter(pe_filter), .pe_product(pe_product),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
   );

   always #5 clock = ~clock;

   // PE: sign-magnitude multiply, 8-bit wrap, two register stages
   function automatic logic [7:0] pe_fn(input logic [7:0] f, input logic [7:0] w);
      logic [13:0] m;
      logic [7:0]  r;
      m = f[6:0] * w[6:0];
      r = m[7:0];
      return (f[7] ^ w[7]) ? -r : r;
   endfunction

   always @(posedge clock) begin
      pe_s1      <= pe_fn(pe_feature, pe_filter);
      pe_product <= pe_s1;
   end

   always @(negedge clock) begin
      if (!reset && in_valid && in_ready) n_acc++;
      if (in_ready) n_ir++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_cfg(input logic [9:0] len);
      cfg_valid = 1'b1;
      cfg_len = len;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (cfg_ready) break;
      end
      @(posedge clock); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic send_op(input logic [7:0] f, input logic [7:0] w);
      in_valid = 1'b1;
      in_feature = f;
      in_filter = w;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (in_ready) break;
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!out_valid && n < 3000);
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b1;
      in_feature = 8'h55;
      in_filter = 8'h33;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_sum !== 20'd0) begin failures++; $display("FAIL reset_out_sum: got %0d expected 0", out_sum); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (pe_feature !== 8'h00) begin failures++; $display("FAIL reset_pe_feature: got %0h expected 0 with idle offer", pe_feature); end
      checks++; if (pe_filter !== 8'h00) begin failures++; $display("FAIL reset_pe_filter: got %0h expected 0 with idle offer", pe_filter); end
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_basic();
      int n;
      exp_q.push_back(20'd39);
      send_cfg(10'd4);
      checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_start: got in_ready=%b busy=%b expected 1 1", in_ready, busy); end
      send_op(8'd3, 8'd2);
      send_op(8'd5, 8'd5);
      send_op(8'd1, 8'h87);
      send_op(8'd15, 8'd1);
      wait_valid(n);
      checks++; if (n !== 3) begin failures++; $display("FAIL basic_latency: got %0d edges expected 2", n - 1); end
      exp_v = exp_q.pop_front();
      checks++; if (!out_valid || out_sum !== exp_v) begin failures++; $display("FAIL basic_sum: got valid=%b sum=%0d expected %0d", out_valid, out_sum, exp_v); end
      take_result();
      @(negedge clock);
      checks++; if (out_valid !== 1'b0 || cfg_ready !== 1'b1) begin failures++; $display("FAIL basic_release: got out_valid=%b cfg_ready=%b expected 0 1", out_valid, cfg_ready); end
   endtask

   task automatic test_zero_len();
      int n;
      int ir0;
      ir0 = n_ir;
      exp_q.push_back(20'd0);
      send_cfg(10'd0);
      wait_valid(n);
      checks++; if (n !== 1) begin failures++; $display("FAIL zero_latency: got %0d negedges expected 1", n); end
      exp_v = exp_q.pop_front();
      checks++; if (!out_valid || out_sum !== exp_v) begin failures++; $display("FAIL zero_sum: got valid=%b sum=%0d expected %0d", out_valid, out_sum, exp_v); end
      take_result();
      @(negedge clock);
      checks++; if (n_ir !== ir0) begin failures++; $display("FAIL zero_in_ready: got %0d cycles high expected 0", n_ir - ir0); end
   endtask

   task automatic test_stalls();
      logic [7:0] fs[3] = '{8'h84, 8'd9, 8'h7F};
      logic [7:0] ws[3] = '{8'd3, 8'd9, 8'd2};
      bit   pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int   idx = 0;
      int   n;
      int   a0;
      bit   stable = 1'b1;
      a0 = n_acc;
      exp_q.push_back(20'd67);
      send_cfg(10'd3);
      for (int i = 0; i < 5; i++) begin
         in_valid = pat[i];
         if (pat[i]) begin
            in_feature = fs[idx];
            in_filter = ws[idx];
            idx++;
         end
         @(posedge clock); #1;
      end
      in_valid = 1'b1;
      in_feature = 8'h11;
      in_filter = 8'h22;
      wait_valid(n);
      checks++; if (n !== 3) begin failures++; $display("FAIL stall_latency: got %0d edges expected 2", n - 1); end
      exp_v = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         if (!out_valid || out_sum !== exp_v) stable = 1'b0;
         @(negedge clock);
      end
      checks++; if (!stable || out_sum !== exp_v) begin failures++; $display("FAIL stall_hold_sum: got valid=%b sum=%0d expected %0d held", out_valid, out_sum, exp_v); end
      checks++; if (n_acc - a0 !== 3) begin failures++; $display("FAIL stall_consumed: got %0d expected 3", n_acc - a0); end
      in_valid = 1'b0;
      take_result();
   endtask

   task automatic test_reset_mid_job();
      int n;
      send_cfg(10'd8);
      repeat (4) send_op(8'd7, 8'd7);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL midreset_idle: got cfg_ready=%b busy=%b in_ready=%b expected 1 0 0", cfg_ready, busy, in_ready); end
      checks++; if (out_sum !== 20'd0) begin failures++; $display("FAIL midreset_acc: got %0d expected 0", out_sum); end
      exp_q.push_back(20'd6);
      send_cfg(10'd1);
      send_op(8'd2, 8'd3);
      wait_valid(n);
      exp_v = exp_q.pop_front();
      checks++; if (!out_valid || out_sum !== exp_v) begin failures++; $display("FAIL midreset_sum: got valid=%b sum=%0d expected %0d", out_valid, out_sum, exp_v); end
      take_result();
   endtask

   task automatic test_back_to_back();
      int n;
      exp_q.push_back(20'hFFFF3);
      exp_q.push_back(20'd31713);
      send_cfg(10'd2);
      send_op(8'h83, 8'd4);
      send_op(8'h81, 8'd1);
      wait_valid(n);
      exp_v = exp_q.pop_front();
      checks++; if (!out_valid || out_sum !== exp_v) begin failures++; $display("FAIL b2b_first_sum: got valid=%b sum=%0h expected %0h", out_valid, out_sum, exp_v); end
      cfg_valid = 1'b1;
      cfg_len = 10'd1023;
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      checks++; if (cfg_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: got cfg_ready=%b out_valid=%b expected 1 0", cfg_ready, out_valid); end
      @(posedge clock); #1;
      cfg_valid = 1'b0;
      checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_second_start: got busy=%b in_ready=%b expected 1 1", busy, in_ready); end
      for (int i = 0; i < 1023; i++) send_op(8'd15, 8'h8F);
      wait_valid(n);
      checks++; if (n !== 3) begin failures++; $display("FAIL b2b_latency: got %0d edges expected 2", n - 1); end
      exp_v = exp_q.pop_front();
      checks++; if (!out_valid || out_sum !== exp_v) begin failures++; $display("FAIL b2b_wrap_sum: got valid=%b sum=%0d expected %0d", out_valid, out_sum, exp_v); end
      take_result();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_stalls();
      test_reset_mid_job();
      test_back_to_back();
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
